// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle for the iterative multiply/divide
//                unit. The requester side (pipeline) uses the master modport;
//                the muldiv_unit uses the slave modport.
//                Also provides the shared ALU_* op-code defines when the
//                surrounding design has not already supplied them.
//  Signals     : start   - request strobe (sampled only while idle)
//                op      - 5-bit ALU op code
//                a, b    - rs1 / rs2 operands
//                flush   - abort in-flight operation
//                busy    - unit not idle
//                done    - one-cycle completion pulse
//                result  - final value, held until the next completion/reset
//                illegal - qualifies done: op code was not supported
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef ALU_MUL
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`define ALU_DIV    5'd20
`define ALU_DIVU   5'd21
`define ALU_REM    5'd22
`define ALU_REMU   5'd23
`endif

interface muldiv_unit_if;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, illegal
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Multiplies with a
//                32-step shift-add on operand magnitudes; divides with a
//                32-step restoring divider on magnitudes. Signs are applied
//                once the iterations finish. Divide-by-zero, signed overflow
//                and unsupported op codes complete in a single cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - muldiv_unit_if.slave request/response bundle
//  Config      : MULDIV_DIV_EN - when defined, DIV/DIVU/REM/REMU are built;
//                otherwise those codes complete as illegal ops.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef ALU_MUL
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`define ALU_DIV    5'd20
`define ALU_DIVU   5'd21
`define ALU_REM    5'd22
`define ALU_REMU   5'd23
`endif

module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] mcand_q,   mcand_d;    // multiplicand or divisor magnitude
    logic [63:0] prod_q,    prod_d;     // {acc/remainder, multiplier/quotient}
    logic        neg_q,     neg_d;      // negate the selected result at the end
    logic        res_hi_q,  res_hi_d;   // deliver upper half of prod_q
    logic        ill_q,     ill_d;      // pending illegal flag for this request
    logic [31:0] result_q,  result_d;
    logic        done_q,    done_d;
    logic        illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
    logic        div_op_q,  div_op_d;   // sign fix is 32-bit for divide ops
`endif

    // ------------------------------------------------------------------
    // Op decode of the incoming request
    // ------------------------------------------------------------------
    logic w_is_mul;
    logic w_a_signed;
    logic w_b_signed;
    logic w_take_hi;
`ifdef MULDIV_DIV_EN
    logic w_is_div;
    logic w_is_rem;
    logic w_ovf;
`endif

    always_comb begin
        w_is_mul   = 1'b0;
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        w_take_hi  = 1'b0;
`ifdef MULDIV_DIV_EN
        w_is_div   = 1'b0;
        w_is_rem   = 1'b0;
`endif
        case (bus.op)
            `ALU_MUL: begin
                w_is_mul = 1'b1;
            end
            `ALU_MULH: begin
                w_is_mul   = 1'b1;
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
                w_take_hi  = 1'b1;
            end
            `ALU_MULHSU: begin
                w_is_mul   = 1'b1;
                w_a_signed = 1'b1;
                w_take_hi  = 1'b1;
            end
            `ALU_MULHU: begin
                w_is_mul  = 1'b1;
                w_take_hi = 1'b1;
            end
`ifdef MULDIV_DIV_EN
            `ALU_DIV: begin
                w_is_div   = 1'b1;
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            `ALU_DIVU: begin
                w_is_div = 1'b1;
            end
            `ALU_REM: begin
                w_is_div   = 1'b1;
                w_is_rem   = 1'b1;
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            `ALU_REMU: begin
                w_is_div = 1'b1;
                w_is_rem = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_a_neg = w_a_signed & bus.a[31];
    assign w_b_neg = w_b_signed & bus.b[31];
    assign w_a_mag = w_a_neg ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag = w_b_neg ? (~bus.b + 32'd1) : bus.b;

`ifdef MULDIV_DIV_EN
    // Only the signed forms can overflow; both divide and remainder care.
    assign w_ovf = w_a_signed && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
`endif

    // ------------------------------------------------------------------
    // Datapath steps
    // ------------------------------------------------------------------
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the 65-bit {carry,acc,mplier} right.
    logic [32:0] w_add;
    logic [63:0] w_mul_step;

    assign w_add      = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
    assign w_mul_step = prod_q[0] ? {w_add, prod_q[31:1]} : {1'b0, prod_q[63:1]};

`ifdef MULDIV_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the trial difference when it does not borrow. The remainder stays
    // below the divisor, so the shifted value never needs more than 33 bits.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_div_step;

    assign w_shift    = {prod_q[63:32], prod_q[31]};
    assign w_diff     = w_shift - {1'b0, mcand_q};
    assign w_div_step = w_diff[32] ? {w_shift[31:0], prod_q[30:0], 1'b0}
                                   : {w_diff[31:0],  prod_q[30:0], 1'b1};
`endif

    // Final sign fix. Multiplies negate the full 64-bit product before
    // selecting a half; divides negate only the selected 32-bit half.
    logic [63:0] w_prod_neg;
    logic [31:0] w_sel;
    logic [31:0] w_final;

    assign w_prod_neg = ~prod_q + 64'd1;
    assign w_sel      = res_hi_q ? prod_q[63:32] : prod_q[31:0];

    always_comb begin
        w_final = w_sel;
        if (neg_q) begin
            w_final = res_hi_q ? w_prod_neg[63:32] : w_prod_neg[31:0];
`ifdef MULDIV_DIV_EN
            if (div_op_q) begin
                w_final = ~w_sel + 32'd1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        res_hi_d  = res_hi_q;
        ill_d     = ill_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
        div_op_d  = div_op_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    cnt_d    = 5'd0;
                    neg_d    = 1'b0;
                    ill_d    = 1'b0;
                    res_hi_d = 1'b0;
                    mcand_d  = w_a_mag;
                    prod_d   = {32'd0, w_b_mag};
`ifdef MULDIV_DIV_EN
                    div_op_d = 1'b0;
`endif
                    if (w_is_mul) begin
                        state_d  = S_MUL;
                        neg_d    = w_a_neg ^ w_b_neg;
                        res_hi_d = w_take_hi;
                    end
`ifdef MULDIV_DIV_EN
                    else if (w_is_div) begin
                        div_op_d = 1'b1;
                        // Fast-path values are parked in the low half with
                        // no sign fix, so DONE delivers them unchanged.
                        if (bus.b == 32'd0) begin
                            state_d = S_DONE;
                            prod_d  = {32'd0, (w_is_rem ? bus.a : 32'hFFFF_FFFF)};
                        end else if (w_ovf) begin
                            state_d = S_DONE;
                            prod_d  = {32'd0, (w_is_rem ? 32'd0 : 32'h8000_0000)};
                        end else begin
                            state_d  = S_DIV;
                            mcand_d  = w_b_mag;
                            prod_d   = {32'd0, w_a_mag};
                            neg_d    = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
                            res_hi_d = w_is_rem;
                        end
                    end
`endif
                    else begin
                        state_d = S_DONE;
                        prod_d  = 64'd0;
                        ill_d   = 1'b1;
                    end
                end
            end

            S_MUL: begin
                prod_d = w_mul_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_DONE;
                end
            end

`ifdef MULDIV_DIV_EN
            S_DIV: begin
                prod_d = w_div_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                // Result and flags are registered on the way out, so the
                // done pulse appears in the cycle after DONE.
                state_d   = S_IDLE;
                result_d  = w_final;
                done_d    = 1'b1;
                illegal_d = ill_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A kill drops the operation without touching the visible result.
        if ((state_q != S_IDLE) && bus.flush) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            done_d    = 1'b0;
            illegal_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'd0;
            prod_q    <= 64'd0;
            neg_q     <= 1'b0;
            res_hi_q  <= 1'b0;
            ill_q     <= 1'b0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_op_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            res_hi_q  <= res_hi_d;
            ill_q     <= ill_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            div_op_q  <= div_op_d;
`endif
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed vector table,
//                randomized ops against an arithmetic reference model, and
//                hand sequences for flush, reset and ignored-start cases.
//                Expectations follow MULDIV_DIV_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef ALU_MUL
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`define ALU_DIV    5'd20
`define ALU_DIVU   5'd21
`define ALU_REM    5'd22
`define ALU_REMU   5'd23
`endif

module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Reference: plain 64-bit products of sign/zero-extended operands and the
    // language's own signed division/remainder.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        logic [63:0] sa, ua, sb, ub, p;
        bit          is_div_op;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        r   = 32'd0;
        ill = 1'b0;
        lat = 33;
        is_div_op = (op == `ALU_DIV) || (op == `ALU_DIVU) || (op == `ALU_REM) || (op == `ALU_REMU);
        if (op == `ALU_MUL) begin
            p = ua * ub; r = p[31:0];
        end else if (op == `ALU_MULH) begin
            p = sa * sb; r = p[63:32];
        end else if (op == `ALU_MULHSU) begin
            p = sa * ub; r = p[63:32];
        end else if (op == `ALU_MULHU) begin
            p = ua * ub; r = p[63:32];
        end else if (is_div_op && DIV_EN) begin
            if (b == 32'd0) begin
                lat = 1;
                r = ((op == `ALU_DIV) || (op == `ALU_DIVU)) ? 32'hFFFF_FFFF : a;
            end else if (((op == `ALU_DIV) || (op == `ALU_REM)) &&
                         (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                lat = 1;
                r = (op == `ALU_DIV) ? 32'h8000_0000 : 32'd0;
            end else begin
                case (op)
                    `ALU_DIV:  r = $signed(a) / $signed(b);
                    `ALU_DIVU: r = a / b;
                    `ALU_REM:  r = $signed(a) % $signed(b);
                    default:   r = a % b;
                endcase
            end
        end else begin
            ill = 1'b1;
            lat = 1;
        end
    endfunction

    // Issue one request from an idle point (#1 after an edge) and wait for
    // done. lat counts edges from the accept edge; -1 means no done seen.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat,
                         output int busy_cnt);
        bit got;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0; busy_cnt = 0; res = 32'd0; ill = 1'b0; got = 1'b0;
        while (!got && lat < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
            if (bus.done) begin
                got = 1'b1;
                res = bus.result;
                ill = bus.illegal;
            end
        end
        if (!got) lat = -1;
    endtask

    logic [31:0] r, er;
    logic        il, eil;
    int          lat, elat, bcnt, dcnt;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] ops[9];
        ops = '{`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU,
                `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU, 5'd5};

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 5'd0; bus.a = 32'd0; bus.b = 32'd0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy",    {31'd0, bus.busy},    32'd0);
        chk("reset_done",    {31'd0, bus.done},    32'd0);
        chk("reset_result",  bus.result,           32'd0);
        chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- directed vector table ----------------
        add_vec(`ALU_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 33);
        add_vec(`ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        add_vec(`ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        add_vec(`ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 33);
        add_vec(`ALU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        add_vec(`ALU_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, 33);
        add_vec(`ALU_DIV,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
        add_vec(`ALU_REM,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
        add_vec(`ALU_DIVU,   32'd77,        32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, 1);
        add_vec(`ALU_REMU,   32'd1234,      32'd0, DIV_EN ? 32'd1234      : 32'd0, !DIV_EN, 1);
        add_vec(`ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, !DIV_EN, 1);
        add_vec(`ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, !DIV_EN, 1);
        add_vec(`ALU_DIVU,   32'd100,       32'd7, DIV_EN ? 32'd14 : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
        add_vec(`ALU_REMU,   32'd100,       32'd7, DIV_EN ? 32'd2  : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
        add_vec(5'd0,        32'd5,         32'd6, 32'd0, 1'b1, 1);
        add_vec(5'd31,       32'd5,         32'd6, 32'd0, 1'b1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, il, lat, bcnt);
            chk($sformatf("vec%0d_result", i),  r,            vecs[i].res);
            chk($sformatf("vec%0d_illegal", i), {31'd0, il},  {31'd0, vecs[i].ill});
            chk($sformatf("vec%0d_latency", i), 32'(lat),     32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy", i),    32'(bcnt),    32'(vecs[i].lat));
        end

        // done is a single-cycle pulse
        tick();
        chk("done_pulse_width", {31'd0, bus.done}, 32'd0);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            int          sel;
            op  = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = $urandom_range(1, 15);
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) a = $urandom_range(0, 255);
            model(op, a, b, er, eil, elat);
            do_op(op, a, b, r, il, lat, bcnt);
            chk($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, op, a, b), r, er);
            chk($sformatf("rnd%0d_illegal", i), {31'd0, il}, {31'd0, eil});
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        // ---------------- start while busy is ignored ----------------
        bus.op = `ALU_MUL; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();                         // accept edge
        bus.start = 1'b0;
        repeat (4) tick();
        bus.op = `ALU_MULHU; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        tick();                         // accept+5
        bus.start = 1'b0;
        lat = 5; r = 32'd0;
        while (lat < 100) begin
            tick();
            lat++;
            if (bus.done) begin
                r = bus.result;
                break;
            end
        end
        chk("ignored_start_latency", 32'(lat), 32'd33);
        chk("ignored_start_result",  r,        32'd15);
        tick();
        chk("ignored_start_idle", {31'd0, bus.busy}, 32'd0);

        // ---------------- flush mid-operation ----------------
        bus.op = `ALU_MUL; bus.a = 32'd1000; bus.b = 32'd1000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.op = `ALU_MULHU; bus.start = 1'b1;
        tick();                         // accept+5
        bus.start = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();                         // accept+10
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            tick();
            if (bus.done) dcnt++;
        end
        chk("flush_no_done",     32'(dcnt),  32'd0);
        chk("flush_result_kept", bus.result, 32'd15);
        do_op(`ALU_MUL, 32'd6, 32'd7, r, il, lat, bcnt);
        chk("after_flush_result",  r,        32'd42);
        chk("after_flush_latency", 32'(lat), 32'd33);

        // ---------------- flush beats start in IDLE ----------------
        bus.op = `ALU_MUL; bus.a = 32'd2; bus.b = 32'd2; bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            tick();
            if (bus.done || bus.busy) dcnt++;
        end
        chk("flush_start_not_accepted", 32'(dcnt),  32'd0);
        chk("flush_start_result",       bus.result, 32'd42);

        // ---------------- reset mid-operation ----------------
        bus.op = `ALU_MUL; bus.a = 32'hFFFF; bus.b = 32'hFFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();                         // accept+20
        rst = 1'b0;
        chk("rst_mid_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_mid_done",    {31'd0, bus.done},    32'd0);
        chk("rst_mid_result",  bus.result,           32'd0);
        chk("rst_mid_illegal", {31'd0, bus.illegal}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            tick();
            if (bus.done) dcnt++;
        end
        chk("rst_mid_no_done", 32'(dcnt), 32'd0);
        do_op(`ALU_MULHU, 32'h0001_0000, 32'h0001_0000, r, il, lat, bcnt);
        chk("after_rst_result",  r,        32'd1);
        chk("after_rst_latency", 32'(lat), 32'd33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
